// File: rtl/window_pkg.sv
// window_pkg: shared types for the 3x3 window generator.
//   state_t   - window_gen FSM states
//   PIX_W_DEF - default pixel width (packed RGB888, R in [23:16])
//   pixel_t   - pixel at the default width
package window_pkg;

  localparam int PIX_W_DEF = 24;

  typedef logic [PIX_W_DEF-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/window_gen_if.sv
// window_gen_if: pixel stream in, 3x3 window out.
//   pixel_in/pixel_valid/sof/eol  - raster-order pixel stream (source -> window_gen)
//   window_0..window_8            - 3x3 neighbourhood, row-major, window_4 centre
//   window_valid                  - one-cycle flag per complete window
//   line_err                      - only with WINDOW_GEN_LINE_ERR_EN: eol / line length disagree
// master: stream source / window sink.  slave: window_gen.
interface window_gen_if #(
  parameter int PIX_W = window_pkg::PIX_W_DEF
);
  logic [PIX_W-1:0] pixel_in;
  logic             pixel_valid;
  logic             sof;
  logic             eol;
  logic [PIX_W-1:0] window_0, window_1, window_2;
  logic [PIX_W-1:0] window_3, window_4, window_5;
  logic [PIX_W-1:0] window_6, window_7, window_8;
  logic             window_valid;
`ifdef WINDOW_GEN_LINE_ERR_EN
  logic             line_err;
`endif

  modport master (
    output pixel_in, pixel_valid, sof, eol,
    input  window_0, window_1, window_2, window_3, window_4,
           window_5, window_6, window_7, window_8, window_valid
`ifdef WINDOW_GEN_LINE_ERR_EN
    , input line_err
`endif
  );

  modport slave (
    input  pixel_in, pixel_valid, sof, eol,
    output window_0, window_1, window_2, window_3, window_4,
           window_5, window_6, window_7, window_8, window_valid
`ifdef WINDOW_GEN_LINE_ERR_EN
    , output line_err
`endif
  );

endinterface

// File: rtl/line_buffer.sv
// line_buffer: one line of pixels, 1 write port / 1 registered read port.
//   clk               - clock
//   wr_en/wr_addr/wr_data - write port
//   rd_addr/rd_data       - read port, rd_data valid the cycle after rd_addr
// A read and write to the same address in one cycle returns the new data
// (write-first), so a prefetching reader never sees a stale word.
// Contents are not reset.
module line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 24,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= (wr_en && wr_addr == rd_addr) ? wr_data : mem[rd_addr];
  end

endmodule

// File: rtl/window_gen.sv
// window_gen: builds a 3x3 pixel neighbourhood from a raster pixel stream.
//   clk   - clock, rising edge
//   n_rst - synchronous active-low reset
//   bus   - window_gen_if.slave: pixel stream in, window_0..8 / window_valid out
// Parameters: IMG_WIDTH (pixels per line, 4..2048), PIX_W (pixel width).
// Optional: define WINDOW_GEN_LINE_ERR_EN to add bus.line_err, a one-cycle
// pulse when eol and the column count disagree.
//
// Two line buffers hold rows r-1 and r-2. They are read one cycle ahead
// (address = column of the next pixel) so the column for the accepted pixel
// is on hand in the same cycle and the window lands with latency 1.
module window_gen
  import window_pkg::*;
#(
  parameter int IMG_WIDTH = 640,
  parameter int PIX_W     = PIX_W_DEF
) (
  input  logic         clk,
  input  logic         n_rst,
  window_gen_if.slave  bus
);

  localparam int            CW       = $clog2(IMG_WIDTH);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] col, col_nxt;
  logic [1:0]    row, row_nxt;

  // take: pixel is processed (IDLE drops everything until sof).
  // p_col/p_row: position of the accepted pixel; sof forces (0,0).
  logic          take;
  logic [CW-1:0] p_col;
  logic [1:0]    p_row;
  logic          at_last;

  assign take    = bus.pixel_valid && (bus.sof || state != IDLE);
  assign p_col   = bus.sof ? '0 : col;
  assign p_row   = bus.sof ? '0 : row;
  assign at_last = (p_col == LAST_COL);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state <= IDLE;
      col   <= '0;
      row   <= '0;
    end else begin
      state <= state_nxt;
      col   <= col_nxt;
      row   <= row_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    row_nxt   = row;
    if (take) begin
      if (bus.eol || at_last) begin
        col_nxt = '0;
        row_nxt = (p_row == 2'd2) ? 2'd2 : p_row + 2'd1;
      end else begin
        col_nxt = p_col + 1'b1;
        row_nxt = p_row;
      end
      if (bus.sof)
        state_nxt = FILL;
      else if (state == FILL && row == 2'd2 && col == '0)
        state_nxt = RUN;
    end
  end

  // Line buffers: [0] holds row r-1 (written with the incoming pixel),
  // [1] holds row r-2 (written with what [0] held at that column).
  logic [1:0][PIX_W-1:0] lb_wdata, lb_rdata;

  assign lb_wdata[0] = bus.pixel_in;
  assign lb_wdata[1] = lb_rdata[0];

  for (genvar i = 0; i < 2; i++) begin : g_lb
    line_buffer #(
      .DEPTH (IMG_WIDTH),
      .WIDTH (PIX_W)
    ) u_lb (
      .clk     (clk),
      .wr_en   (take),
      .wr_addr (p_col),
      .wr_data (lb_wdata[i]),
      .rd_addr (col_nxt),
      .rd_data (lb_rdata[i])
    );
  end

  // win[r][c]: r=0 top row, c=2 newest column.
  logic [2:0][2:0][PIX_W-1:0] win;
  logic                       win_vld;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      win     <= '0;
      win_vld <= 1'b0;
    end else begin
      win_vld <= take && !bus.sof && state == RUN && col >= CW'(2);
      if (take) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= lb_rdata[1];
        win[1][2] <= lb_rdata[0];
        win[2][2] <= bus.pixel_in;
      end
    end
  end

  assign bus.window_0     = win[0][0];
  assign bus.window_1     = win[0][1];
  assign bus.window_2     = win[0][2];
  assign bus.window_3     = win[1][0];
  assign bus.window_4     = win[1][1];
  assign bus.window_5     = win[1][2];
  assign bus.window_6     = win[2][0];
  assign bus.window_7     = win[2][1];
  assign bus.window_8     = win[2][2];
  assign bus.window_valid = win_vld;

`ifdef WINDOW_GEN_LINE_ERR_EN
  logic line_err_q;

  always_ff @(posedge clk) begin
    if (!n_rst) line_err_q <= 1'b0;
    else        line_err_q <= take && (bus.eol != at_last);
  end

  assign bus.line_err = line_err_q;
`endif

endmodule

// File: tb/tb_window_gen.sv
// tb_window_gen: randomized/self-checking bench for window_gen (IMG_WIDTH=8).
// The reference model stores every accepted pixel of the current frame in a
// 2-D image indexed by true (row, col) and reads expected windows from it.
module tb_window_gen;
  import window_pkg::*;

  localparam int W  = 8;
  localparam int PW = PIX_W_DEF;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  window_gen_if #(.PIX_W(PW)) bus ();

  window_gen #(.IMG_WIDTH(W), .PIX_W(PW)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int tests_run = 0;
  int fails     = 0;

  // reference model state
  pixel_t           img [0:63][0:W-1];
  bit               in_frame;
  int               mr, mc;
  bit               exp_valid, exp_err;
  logic [9*PW-1:0]  exp_win;

  function automatic logic [9*PW-1:0] dut_win();
    return {bus.window_8, bus.window_7, bus.window_6, bus.window_5, bus.window_4,
            bus.window_3, bus.window_2, bus.window_1, bus.window_0};
  endfunction

  // Drive one cycle, update the model, sample #1 after the edge.
  task automatic step(input bit v, input bit s, input bit e, input pixel_t pix);
    int r, c;
    bus.pixel_valid = v; bus.sof = s; bus.eol = e; bus.pixel_in = pix;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    if (v && s) begin in_frame = 1'b1; mr = 0; mc = 0; end
    if (v && in_frame) begin
      r = mr; c = mc;
      img[r % 64][c] = pix;
      exp_valid = (r >= 2 && c >= 2);
      if (exp_valid)
        for (int k = 0; k < 9; k++)
          exp_win[k*PW +: PW] = img[(r - 2 + k / 3) % 64][c - 2 + k % 3];
      exp_err = (e != (c == W - 1));
      if (e || c == W - 1) begin mc = 0; mr = r + 1; end
      else mc = c + 1;
    end
    @(posedge clk); #1;
    bus.pixel_valid = 1'b0; bus.sof = 1'b0; bus.eol = 1'b0;
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    bus.pixel_valid = 1'b0; bus.sof = 1'b0; bus.eol = 1'b0; bus.pixel_in = '0;
    @(posedge clk); #1;
    n_rst = 1'b1;
    in_frame = 1'b0; mr = 0; mc = 0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    bus.pixel_valid = 1'b1; bus.sof = 1'b1; bus.eol = 1'b0; bus.pixel_in = 24'h123456;
    @(posedge clk); #1;
    tests_run++;
    if (bus.window_valid !== 1'b0) begin
      fails++; $display("FAIL reset_valid got %b exp 0", bus.window_valid);
    end
    tests_run++;
    if (dut_win() !== '0) begin
      fails++; $display("FAIL reset_win got %h exp 0", dut_win());
    end
`ifdef WINDOW_GEN_LINE_ERR_EN
    tests_run++;
    if (bus.line_err !== 1'b0) begin
      fails++; $display("FAIL reset_line_err got %b exp 0", bus.line_err);
    end
`endif
    bus.pixel_valid = 1'b0; bus.sof = 1'b0;
    n_rst = 1'b1;
    in_frame = 1'b0; mr = 0; mc = 0;
  endtask

  task automatic test_basic(input bit gaps);
    int nvld = 0;
    do_reset();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < W; c++) begin
        if (gaps) begin
          step(1'b0, 1'b0, 1'b0, pixel_t'($urandom));
          tests_run++;
          if (bus.window_valid !== 1'b0) begin
            fails++; $display("FAIL gap_idle_valid r%0d c%0d got %b exp 0", r, c, bus.window_valid);
          end
        end
        step(1'b1, r == 0 && c == 0, c == W - 1, pixel_t'(r * 16 + c));
        nvld += int'(bus.window_valid === 1'b1);
        tests_run++;
        if (bus.window_valid !== exp_valid) begin
          fails++; $display("FAIL basic_valid gaps%0d r%0d c%0d got %b exp %b", gaps, r, c, bus.window_valid, exp_valid);
        end
        if (exp_valid) begin
          tests_run++;
          if (dut_win() !== exp_win) begin
            fails++; $display("FAIL basic_win r%0d c%0d got %h exp %h", r, c, dut_win(), exp_win);
          end
        end
        if (r == 2 && c == 2) begin
          tests_run++;
          if (bus.window_0 !== 24'h00 || bus.window_4 !== 24'h11 || bus.window_8 !== 24'h22) begin
            fails++; $display("FAIL first_window got w0=%h w4=%h w8=%h exp 000000/000011/000022",
                              bus.window_0, bus.window_4, bus.window_8);
          end
        end
      end
    tests_run++;
    if (nvld !== W - 2) begin
      fails++; $display("FAIL basic_count gaps%0d got %0d exp %0d", gaps, nvld, W - 2);
    end
  endtask

  task automatic test_no_sof();
    int nvld = 0;
    do_reset();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < W; c++) begin
        step(1'b1, 1'b0, c == W - 1, pixel_t'(r * 16 + c));
        nvld += int'(bus.window_valid === 1'b1);
      end
    tests_run++;
    if (nvld !== 0) begin
      fails++; $display("FAIL no_sof_count got %0d exp 0", nvld);
    end
  endtask

  task automatic test_sof_restart();
    do_reset();
    for (int i = 0; i < 3 * W + 5; i++) begin
      step(1'b1, i == 0, (i % W) == W - 1, pixel_t'((i / W) * 16 + i % W));
      tests_run++;
      if (bus.window_valid !== exp_valid) begin
        fails++; $display("FAIL restart_old_valid i%0d got %b exp %b", i, bus.window_valid, exp_valid);
      end
      if (exp_valid) begin
        tests_run++;
        if (dut_win() !== exp_win) begin
          fails++; $display("FAIL restart_old_win i%0d got %h exp %h", i, dut_win(), exp_win);
        end
      end
    end
    // sof lands on what would have been (3,5)
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < W; c++) begin
        step(1'b1, r == 0 && c == 0, c == W - 1, pixel_t'(r * 16 + c));
        tests_run++;
        if (bus.window_valid !== ((r == 2 && c >= 2) ? 1'b1 : 1'b0)) begin
          fails++; $display("FAIL restart_valid r%0d c%0d got %b exp %b", r, c, bus.window_valid, exp_valid);
        end
        if (exp_valid) begin
          tests_run++;
          if (dut_win() !== exp_win) begin
            fails++; $display("FAIL restart_win r%0d c%0d got %h exp %h", r, c, dut_win(), exp_win);
          end
        end
        if (r == 2 && c == 2) begin
          tests_run++;
          if (bus.window_4 !== 24'h11) begin
            fails++; $display("FAIL restart_centre got %h exp 000011", bus.window_4);
          end
        end
      end
  endtask

  task automatic test_reset_mid();
    int nvld = 0;
    do_reset();
    for (int i = 0; i < 2 * W + 4; i++)
      step(1'b1, i == 0, (i % W) == W - 1, pixel_t'((i / W) * 16 + i % W));
    // pixel (2,4) presented while reset is low
    n_rst = 1'b0;
    bus.pixel_valid = 1'b1; bus.pixel_in = 24'h24;
    @(posedge clk); #1;
    n_rst = 1'b1; bus.pixel_valid = 1'b0;
    in_frame = 1'b0; mr = 0; mc = 0;
    tests_run++;
    if (bus.window_valid !== 1'b0 || dut_win() !== '0) begin
      fails++; $display("FAIL mid_reset_outputs got vld %b win %h exp 0", bus.window_valid, dut_win());
    end
    for (int i = 5; i < 2 * W; i++) begin
      step(1'b1, 1'b0, (i % W) == W - 1, pixel_t'($urandom));
      nvld += int'(bus.window_valid === 1'b1);
    end
    tests_run++;
    if (nvld !== 0) begin
      fails++; $display("FAIL mid_reset_no_sof_count got %0d exp 0", nvld);
    end
    for (int i = 0; i < 3 * W; i++) begin
      step(1'b1, i == 0, (i % W) == W - 1, pixel_t'($urandom));
      tests_run++;
      if (bus.window_valid !== exp_valid) begin
        fails++; $display("FAIL mid_reset_new_valid i%0d got %b exp %b", i, bus.window_valid, exp_valid);
      end
      if (exp_valid) begin
        tests_run++;
        if (dut_win() !== exp_win) begin
          fails++; $display("FAIL mid_reset_new_win i%0d got %h exp %h", i, dut_win(), exp_win);
        end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < W; c++) begin
        while ($urandom_range(0, 2) == 0) begin
          step(1'b0, 1'b0, 1'b0, pixel_t'($urandom));
          tests_run++;
          if (bus.window_valid !== 1'b0) begin
            fails++; $display("FAIL random_idle_valid r%0d c%0d got %b exp 0", r, c, bus.window_valid);
          end
        end
        // eol at the last column is optional: the width alone must wrap
        step(1'b1, r == 0 && c == 0, c == W - 1 && $urandom_range(0, 1) == 1, pixel_t'($urandom));
        tests_run++;
        if (bus.window_valid !== exp_valid) begin
          fails++; $display("FAIL random_valid r%0d c%0d got %b exp %b", r, c, bus.window_valid, exp_valid);
        end
        if (exp_valid) begin
          tests_run++;
          if (dut_win() !== exp_win) begin
            fails++; $display("FAIL random_win r%0d c%0d got %h exp %h", r, c, dut_win(), exp_win);
          end
        end
`ifdef WINDOW_GEN_LINE_ERR_EN
        tests_run++;
        if (bus.line_err !== exp_err) begin
          fails++; $display("FAIL random_line_err r%0d c%0d got %b exp %b", r, c, bus.line_err, exp_err);
        end
`endif
      end
  endtask

`ifdef WINDOW_GEN_LINE_ERR_EN
  task automatic test_line_err();
    int nerr = 0;
    do_reset();
    // row 0 ends early at col 5; rows 1 and 2 are full
    for (int i = 0; i < 6 + 2 * W; i++) begin
      int c;
      c = (i < 6) ? i : (i - 6) % W;
      step(1'b1, i == 0, (i == 5) || (i >= 6 && c == W - 1), pixel_t'($urandom));
      nerr += int'(bus.line_err === 1'b1);
      tests_run++;
      if (bus.line_err !== exp_err) begin
        fails++; $display("FAIL line_err i%0d got %b exp %b", i, bus.line_err, exp_err);
      end
      tests_run++;
      if (bus.window_valid !== exp_valid) begin
        fails++; $display("FAIL line_err_valid i%0d got %b exp %b", i, bus.window_valid, exp_valid);
      end
    end
    tests_run++;
    if (nerr !== 1) begin
      fails++; $display("FAIL line_err_count got %0d exp 1", nerr);
    end
  endtask
`endif

  initial begin
    bus.pixel_in = '0; bus.pixel_valid = 1'b0; bus.sof = 1'b0; bus.eol = 1'b0;
    exp_win = '0;
    test_reset();
    test_basic(1'b0);
    test_basic(1'b1);
    test_no_sof();
    test_sof_restart();
    test_reset_mid();
    test_random();
`ifdef WINDOW_GEN_LINE_ERR_EN
    test_line_err();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
